// File: rtl/pe_top_strait.sv
// Systolic-array processing element: registers and forwards activation/weight,
// accumulates A*W + P_in, and turns the partial-sum register into a scan flop.
module pe_top_strait #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              scan_en,
  input  logic [DATA_W-1:0] A,
  input  logic [DATA_W-1:0] W,
  input  logic [DATA_W-1:0] P_in,
  output logic [DATA_W-1:0] P_out,
  output logic [DATA_W-1:0] A_out,
  output logic [DATA_W-1:0] W_out
);

  logic [DATA_W-1:0] a_p0;
  logic [DATA_W-1:0] w_p0;
  logic [DATA_W-1:0] psum_p1;
  logic [DATA_W-1:0] mac_nxt;
  logic [DATA_W-1:0] psum_nxt;

  // Unsigned multiply-add that wraps modulo 2^DATA_W: only the low product bits matter.
  function automatic logic [DATA_W-1:0] mac_wrap(
    input logic [DATA_W-1:0] a,
    input logic [DATA_W-1:0] w,
    input logic [DATA_W-1:0] p
  );
    logic [DATA_W-1:0] prod;
    prod = a * w;
    return prod + p;
  endfunction

  // Stage p0: operand registers, forwarded east/south regardless of mode
  always_ff @(posedge clk) begin
    if (rst) begin
      a_p0 <= '0;
      w_p0 <= '0;
    end else begin
      a_p0 <= A;
      w_p0 <= W;
    end
  end

  always_comb begin
    mac_nxt  = mac_wrap(a_p0, w_p0, P_in);
    psum_nxt = scan_en ? P_in : mac_nxt;
  end

  // Stage p1: partial-sum register, doubles as a scan flop when scan_en is high
  always_ff @(posedge clk) begin
    if (rst) psum_p1 <= '0;
    else     psum_p1 <= psum_nxt;
  end

  assign A_out = a_p0;
  assign W_out = w_p0;
  assign P_out = psum_p1;

endmodule

// File: tb/tb_pe_top_strait.sv
// Bench for pe_top_strait: directed scenarios plus randomized traffic against a reference model.
module tb_pe_top_strait;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          scan_en;
  logic [DW-1:0] A, W, P_in;
  logic [DW-1:0] P_out, A_out, W_out;

  int checks = 0;
  int errors = 0;

  // reference state: what each register should hold
  logic [DW-1:0] m_a = '0, m_w = '0, m_p = '0;

  pe_top_strait #(.DATA_W(DW)) dut (
    .clk(clk), .rst(rst), .scan_en(scan_en),
    .A(A), .W(W), .P_in(P_in),
    .P_out(P_out), .A_out(A_out), .W_out(W_out)
  );

  always #5 clk = ~clk;

  // One rising edge; the model advances from the inputs present at that edge.
  task automatic tick();
    longint unsigned full;
    logic [DW-1:0] na, nw, np;
    full = {32'h0, m_a} * {32'h0, m_w} + {32'h0, P_in};
    if (rst) begin
      na = '0; nw = '0; np = '0;
    end else begin
      na = A;
      nw = W;
      np = scan_en ? P_in : full[DW-1:0];
    end
    @(posedge clk);
    #1;
    m_a = na; m_w = nw; m_p = np;
  endtask

  task automatic test_reset();
    rst = 1'b1; scan_en = 1'b1; A = 32'h1234_5678; W = 32'h9ABC_DEF0; P_in = 32'h5555_AAAA;
    tick();
    checks++;
    if (P_out !== 32'h0 || A_out !== 32'h0 || W_out !== 32'h0) begin
      errors++;
      $display("FAIL reset: P_out=%h A_out=%h W_out=%h, required all 0", P_out, A_out, W_out);
    end
  endtask

  task automatic test_capture();
    rst = 1'b0; scan_en = 1'b0; A = 2; W = 3; P_in = 4;
    tick();
    checks++;
    if (A_out !== 32'd2 || W_out !== 32'd3 || P_out !== 32'd4) begin
      errors++;
      $display("FAIL capture_edge1: A_out=%0d W_out=%0d P_out=%0d, required 2 3 4", A_out, W_out, P_out);
    end
    tick();
    checks++;
    if (P_out !== 32'd10) begin
      errors++;
      $display("FAIL capture_edge2: P_out=%0d, required 10", P_out);
    end
  endtask

  task automatic test_shift();
    scan_en = 1'b1; P_in = 32'hCAFE_BABE; A = 32'h0000_0011; W = 32'h0000_0022;
    tick();
    checks++;
    if (P_out !== 32'hCAFE_BABE || A_out !== 32'h11 || W_out !== 32'h22) begin
      errors++;
      $display("FAIL shift: P_out=%h A_out=%h W_out=%h, required cafebabe 11 22", P_out, A_out, W_out);
    end
    scan_en = 1'b0;
  endtask

  task automatic test_wrap();
    scan_en = 1'b0; A = 32'hFFFF_FFFF; W = 2; P_in = 1;
    tick(); tick();
    checks++;
    if (P_out !== 32'hFFFF_FFFF) begin
      errors++;
      $display("FAIL wrap_sum: P_out=%h, required ffffffff", P_out);
    end
    A = 32'h0001_0000; W = 32'h0001_0000; P_in = 5;
    tick(); tick();
    checks++;
    if (P_out !== 32'd5) begin
      errors++;
      $display("FAIL wrap_product: P_out=%h, required 00000005", P_out);
    end
  endtask

  task automatic test_mode_switch();
    scan_en = 1'b0; A = 2; W = 3; P_in = 0;
    tick();
    scan_en = 1'b1; P_in = 7;
    tick();
    checks++;
    if (P_out !== 32'd7) begin
      errors++;
      $display("FAIL switch_to_shift: P_out=%0d, required 7", P_out);
    end
    scan_en = 1'b0; P_in = 1;
    tick();
    checks++;
    if (P_out !== 32'd7) begin
      errors++;
      $display("FAIL switch_to_capture: P_out=%0d, required 7", P_out);
    end
  endtask

  task automatic test_reset_mid();
    scan_en = 1'b0; A = 2; W = 3; P_in = 4;
    tick(); tick();
    checks++;
    if (P_out !== 32'd10) begin
      errors++;
      $display("FAIL mid_pre: P_out=%0d, required 10", P_out);
    end
    rst = 1'b1;
    tick();
    checks++;
    if (P_out !== 32'h0 || A_out !== 32'h0 || W_out !== 32'h0) begin
      errors++;
      $display("FAIL mid_reset: P_out=%h A_out=%h W_out=%h, required all 0", P_out, A_out, W_out);
    end
    rst = 1'b0;
    tick();
    checks++;
    if (P_out !== 32'd4) begin
      errors++;
      $display("FAIL mid_after1: P_out=%0d, required 4", P_out);
    end
    tick();
    checks++;
    if (P_out !== 32'd10) begin
      errors++;
      $display("FAIL mid_after2: P_out=%0d, required 10", P_out);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      rst     = ($urandom_range(0, 31) == 0);
      scan_en = ($urandom_range(0, 3) == 0);
      case ($urandom_range(0, 3))
        0:       A = 32'hFFFF_FFFF;
        1:       A = $urandom_range(0, 15);
        default: A = $urandom;
      endcase
      W    = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom;
      P_in = $urandom;
      tick();
      checks++;
      if (P_out !== m_p || A_out !== m_a || W_out !== m_w) begin
        errors++;
        $display("FAIL random[%0d]: P_out=%h A_out=%h W_out=%h, required %h %h %h",
                 i, P_out, A_out, W_out, m_p, m_a, m_w);
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_back_to_back();
    rst = 1'b0; scan_en = 1'b0;
    for (int i = 0; i < 50; i++) begin
      A = $urandom; W = $urandom; P_in = $urandom;
      scan_en = i[0];
      tick();
      checks++;
      if (P_out !== m_p) begin
        errors++;
        $display("FAIL back_to_back[%0d]: P_out=%h, required %h", i, P_out, m_p);
      end
    end
  endtask

  initial begin
    rst = 1'b1; scan_en = 1'b0; A = '0; W = '0; P_in = '0;
    test_reset();
    test_capture();
    test_shift();
    test_wrap();
    test_mode_switch();
    test_reset_mid();
    test_random();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
